alu_sequencer: RTL and testbench

//  Sequences the shared 8-bit ALU (ADD/SR/AND/OR/XOR) so it can execute full 6502 arithmetic/logic ops.

---
 rtl/alu_sequencer_pkg.sv | 57 +++++
 rtl/alu_sequencer_bcd_adjust.sv | 37 +++
 rtl/alu_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg
//   Shared constants and types for the 6502 ALU sequencer:
//   ALU control codes, OP_* request codes, FSM state encoding,
//   the latched request record and the per-op flag write mask.
package alu_sequencer_pkg;

    // Control codes understood by the shared 8-bit ALU
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SR  = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;

    // Sequencer op codes; 12..15 are unknown and complete as no-ops
    localparam logic [3:0] OP_ADC = 4'd0;
    localparam logic [3:0] OP_SBC = 4'd1;
    localparam logic [3:0] OP_CMP = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_ORA = 4'd4;
    localparam logic [3:0] OP_EOR = 4'd5;
    localparam logic [3:0] OP_ASL = 4'd6;
    localparam logic [3:0] OP_LSR = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_ROR = 4'd9;
    localparam logic [3:0] OP_INC = 4'd10;
    localparam logic [3:0] OP_DEC = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_ADJUST = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       carry;
        logic       decimal;
    } req_t;

    // Which of {N,V,Z,C} an op updates
    function automatic logic [3:0] flag_mask(input logic [3:0] op);
        case (op)
            OP_ADC, OP_SBC:                         flag_mask = 4'b1111;
            OP_CMP, OP_ASL, OP_LSR, OP_ROL, OP_ROR: flag_mask = 4'b1011;
            OP_AND, OP_ORA, OP_EOR, OP_INC, OP_DEC: flag_mask = 4'b1010;
            default:                                flag_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic op_known(input logic [3:0] op);
        op_known = (op <= OP_DEC);
    endfunction

endpackage

// File: rtl/alu_sequencer_bcd_adjust.sv
// bcd_adjust
//   Combinational decimal correction for the second ALU pass of ADC/SBC.
//   Ports:
//     is_sbc  in  1  op is SBC (else ADC)
//     hc      in  1  half carry out of bit 3 in the binary pass
//     y1      in  8  binary-pass result byte
//     c1      in  1  binary-pass carry out
//     corr    out 8  value added to y1 in the correction pass
//     c_out   out 1  final decimal carry
module bcd_adjust (
    input  logic       is_sbc,
    input  logic       hc,
    input  logic [7:0] y1,
    input  logic       c1,
    output logic [7:0] corr,
    output logic       c_out
);
    logic lo, hi;

    always_comb begin
        if (is_sbc) begin
            // A borrow from a nibble means that nibble must lose 6
            // (0xFA = -6 in the low nibble, 0xA0 = -6 in the high nibble).
            lo    = !hc;
            hi    = !c1;
            corr  = (lo && hi) ? 8'h9A :
                    lo         ? 8'hFA :
                    hi         ? 8'hA0 : 8'h00;
            c_out = c1;
        end else begin
            lo    = hc || (y1[3:0] > 4'd9);
            hi    = c1 || (y1 > 8'h99);
            corr  = {(hi ? 4'h6 : 4'h0), (lo ? 4'h6 : 4'h0)};
            c_out = c1 || hi;
        end
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Drives the shared 8-bit ALU to execute 6502 arithmetic/logic ops.
//   One request is accepted in IDLE (valid/ready), executed in EXEC, optionally
//   decimal-corrected in ADJUST, and reported for one cycle in DONE.
//   Ports:
//     clk, reset                      clock, synchronous active-high reset
//     req_valid/req_ready             request handshake (ready only in IDLE)
//     req_op/a/b/carry/decimal        op code, operands, current P.C and P.D
//     alu_control/AI/BI/carry_in      drive to the external ALU (0 when idle/done)
//     alu_Y/carry_out/overflow        ALU results
//     res_valid                       one-cycle result strobe
//     res_data/write/flags/flag_we    result byte, dest write, {N,V,Z,C}, flag mask
module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic       req_carry,
    input  logic       req_decimal,
    output logic [2:0] alu_control,
    output logic [7:0] alu_AI,
    output logic [7:0] alu_BI,
    output logic       alu_carry_in,
    input  logic [7:0] alu_Y,
    input  logic       alu_carry_out,
    input  logic       alu_overflow,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       res_write,
    output logic [3:0] res_flags,
    output logic [3:0] res_flag_we
);
    state_e     state_q, state_d;
    req_t       req_q, req_d;
    logic [7:0] y1_q, y1_d;
    logic       c1_q, c1_d, v1_q, v1_d, hc_q, hc_d;
    logic       res_valid_q, res_valid_d, res_write_q, res_write_d;
    logic [7:0] res_data_q, res_data_d;
    logic [3:0] res_flags_q, res_flags_d, res_flag_we_q, res_flag_we_d;

    logic       is_dec;
    logic [4:0] hc_sum;
    logic [7:0] corr;
    logic       adj_c;
    logic       fin_load, fin_c, fin_v;

    assign is_dec = req_q.decimal && (req_q.op == OP_ADC || req_q.op == OP_SBC);

    bcd_adjust u_bcd (
        .is_sbc (req_q.op == OP_SBC),
        .hc     (hc_q),
        .y1     (y1_q),
        .c1     (c1_q),
        .corr   (corr),
        .c_out  (adj_c)
    );

    // ALU drive depends only on registered state so the ALU sees stable inputs.
    always_comb begin
        alu_control  = ALU_ADD;
        alu_AI       = 8'h00;
        alu_BI       = 8'h00;
        alu_carry_in = 1'b0;
        if (state_q == ST_EXEC) begin
            alu_AI = req_q.a;
            case (req_q.op)
                OP_ADC: begin alu_BI = req_q.b;  alu_carry_in = req_q.carry; end
                OP_SBC: begin alu_BI = ~req_q.b; alu_carry_in = req_q.carry; end
                OP_CMP: begin alu_BI = ~req_q.b; alu_carry_in = 1'b1;        end
                OP_AND: begin alu_control = ALU_AND; alu_BI = req_q.b;       end
                OP_ORA: begin alu_control = ALU_OR;  alu_BI = req_q.b;       end
                OP_EOR: begin alu_control = ALU_XOR; alu_BI = req_q.b;       end
                OP_ASL: alu_BI = req_q.a;
                OP_ROL: begin alu_BI = req_q.a;  alu_carry_in = req_q.carry; end
                OP_LSR: alu_control = ALU_SR;
                OP_ROR: begin alu_control = ALU_SR; alu_carry_in = req_q.carry; end
                OP_INC: alu_BI = 8'h01;
                OP_DEC: alu_BI = 8'hFF;
                default: alu_AI = 8'h00;
            endcase
        end else if (state_q == ST_ADJUST) begin
            alu_AI = y1_q;
            alu_BI = corr;
        end
    end

    // Low-nibble carry of the binary pass, needed by the decimal correction.
    assign hc_sum = {1'b0, alu_AI[3:0]} + {1'b0, alu_BI[3:0]} + {4'b0, alu_carry_in};

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        y1_d          = y1_q;
        c1_d          = c1_q;
        v1_d          = v1_q;
        hc_d          = hc_q;
        res_valid_d   = 1'b0;
        res_data_d    = 8'h00;
        res_write_d   = 1'b0;
        res_flags_d   = 4'h0;
        res_flag_we_d = 4'h0;
        fin_load      = 1'b0;
        fin_c         = alu_carry_out;
        fin_v         = alu_overflow;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_d   = '{op: req_op, a: req_a, b: req_b,
                                carry: req_carry, decimal: req_decimal};
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                y1_d = alu_Y;
                c1_d = alu_carry_out;
                v1_d = alu_overflow;
                hc_d = hc_sum[4];
                if (is_dec) begin
                    state_d = ST_ADJUST;
                end else begin
                    state_d  = ST_DONE;
                    fin_load = 1'b1;
                end
            end
            ST_ADJUST: begin
                state_d  = ST_DONE;
                fin_load = 1'b1;
                fin_c    = adj_c;
                fin_v    = v1_q;
            end
            default: state_d = ST_IDLE;
        endcase

        if (fin_load) begin
            res_valid_d = 1'b1;
            if (op_known(req_q.op)) begin
                res_data_d    = alu_Y;
                res_write_d   = (req_q.op != OP_CMP);
                res_flags_d   = {alu_Y[7], fin_v, (alu_Y == 8'h00), fin_c};
                res_flag_we_d = flag_mask(req_q.op);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            req_q         <= '0;
            y1_q          <= 8'h00;
            c1_q          <= 1'b0;
            v1_q          <= 1'b0;
            hc_q          <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= 8'h00;
            res_write_q   <= 1'b0;
            res_flags_q   <= 4'h0;
            res_flag_we_q <= 4'h0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            y1_q          <= y1_d;
            c1_q          <= c1_d;
            v1_q          <= v1_d;
            hc_q          <= hc_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_write_q   <= res_write_d;
            res_flags_q   <= res_flags_d;
            res_flag_we_q <= res_flag_we_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_write   = res_write_q;
    assign res_flags   = res_flags_q;
    assign res_flag_we = res_flag_we_q;
endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_ready, req_carry, req_decimal;
    logic [3:0] req_op;
    logic [7:0] req_a, req_b;
    logic [2:0] alu_control;
    logic [7:0] alu_AI, alu_BI, alu_Y;
    logic       alu_carry_in, alu_carry_out, alu_overflow;
    logic       res_valid, res_write;
    logic [7:0] res_data;
    logic [3:0] res_flags, res_flag_we;

    int checks = 0;
    int errors = 0;
    // {got, latency[3:0], data, flags, flag_we, write}
    logic [21:0] obs, expv;
    logic [8:0]  alu_sum;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_carry(req_carry), .req_decimal(req_decimal),
        .alu_control(alu_control), .alu_AI(alu_AI), .alu_BI(alu_BI),
        .alu_carry_in(alu_carry_in), .alu_Y(alu_Y), .alu_carry_out(alu_carry_out),
        .alu_overflow(alu_overflow), .res_valid(res_valid), .res_data(res_data),
        .res_write(res_write), .res_flags(res_flags), .res_flag_we(res_flag_we)
    );

    // Behavioural model of the shared ALU
    always_comb begin
        alu_sum       = {1'b0, alu_AI} + {1'b0, alu_BI} + {8'b0, alu_carry_in};
        alu_Y         = 8'h00;
        alu_carry_out = 1'b0;
        alu_overflow  = 1'b0;
        case (alu_control)
            ALU_ADD: begin
                alu_Y         = alu_sum[7:0];
                alu_carry_out = alu_sum[8];
                alu_overflow  = (alu_AI[7] == alu_BI[7]) && (alu_sum[7] != alu_AI[7]);
            end
            ALU_SR: begin
                alu_Y         = {alu_carry_in, alu_AI[7:1]};
                alu_carry_out = alu_AI[0];
            end
            ALU_AND: alu_Y = alu_AI & alu_BI;
            ALU_OR:  alu_Y = alu_AI | alu_BI;
            ALU_XOR: alu_Y = alu_AI ^ alu_BI;
            default: alu_Y = 8'h00;
        endcase
    end

    // Issue one op from IDLE and collect the result; latency counts the
    // cycles from the acceptance edge up to and including the res_valid cycle.
    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic d);
        logic got;
        int   lat;
        logic [7:0] data;
        logic [3:0] fl, we;
        logic wr;
        got = 1'b0; lat = 0; data = 8'h00; fl = 4'h0; we = 4'h0; wr = 1'b0;
        @(negedge clk);
        req_op = op; req_a = a; req_b = b; req_carry = c; req_decimal = d; req_valid = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 8 && !got; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (res_valid) begin
                got = 1'b1; lat = i; data = res_data;
                fl = res_flags; we = res_flag_we; wr = res_write;
            end
        end
        obs = {got, lat[3:0], data, fl, we, wr};
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_valid = 1'b0; req_op = 4'h0; req_a = 8'h00; req_b = 8'h00;
        req_carry = 1'b0; req_decimal = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, res_valid, res_data, res_write, res_flags, res_flag_we} !== {1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b v=%b d=%h w=%b f=%b we=%b, expected rdy=1 rest 0",
                     req_ready, res_valid, res_data, res_write, res_flags, res_flag_we);
        end
        checks++;
        if ({alu_control, alu_AI, alu_BI, alu_carry_in} !== 20'h0) begin
            errors++;
            $display("FAIL reset_alu_drive: got ctl=%h ai=%h bi=%h cin=%b, expected all 0",
                     alu_control, alu_AI, alu_BI, alu_carry_in);
        end
        reset = 1'b0;
    endtask

    task automatic test_arith;
        // 0x50+0x50 = 0xA0: signed overflow, so V is set
        run_op(OP_ADC, 8'h50, 8'h50, 1'b0, 1'b0);
        expv = {1'b1, 4'd2, 8'hA0, 4'b1100, 4'b1111, 1'b1}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL adc_bin: got %h, expected %h", obs, expv); end
        run_op(OP_ADC, 8'h19, 8'h28, 1'b0, 1'b1);
        expv = {1'b1, 4'd3, 8'h47, 4'b0000, 4'b1111, 1'b1}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL adc_dec_19_28: got %h, expected %h", obs, expv); end
        // binary pass 0x9F sets V, final 0x05 with decimal carry
        run_op(OP_ADC, 8'h58, 8'h46, 1'b1, 1'b1);
        expv = {1'b1, 4'd3, 8'h05, 4'b0101, 4'b1111, 1'b1}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL adc_dec_58_46: got %h, expected %h", obs, expv); end
        run_op(OP_SBC, 8'h46, 8'h12, 1'b1, 1'b1);
        expv = {1'b1, 4'd3, 8'h34, 4'b0001, 4'b1111, 1'b1}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL sbc_dec_46_12: got %h, expected %h", obs, expv); end
        run_op(OP_SBC, 8'h12, 8'h21, 1'b1, 1'b1);
        expv = {1'b1, 4'd3, 8'h91, 4'b1000, 4'b1111, 1'b1}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL sbc_dec_12_21: got %h, expected %h", obs, expv); end
        run_op(OP_SBC, 8'h05, 8'h03, 1'b1, 1'b0);
        expv = {1'b1, 4'd2, 8'h02, 4'b0001, 4'b1111, 1'b1}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL sbc_bin: got %h, expected %h", obs, expv); end
    endtask

    task automatic test_compare;
        // decimal flag must not lengthen CMP
        run_op(OP_CMP, 8'h40, 8'h40, 1'b0, 1'b1);
        expv = {1'b1, 4'd2, 8'h00, 4'b0011, 4'b1011, 1'b0}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL cmp_eq: got %h, expected %h", obs, expv); end
        run_op(OP_CMP, 8'h10, 8'h20, 1'b1, 1'b0);
        expv = {1'b1, 4'd2, 8'hF0, 4'b1000, 4'b1011, 1'b0}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL cmp_lt: got %h, expected %h", obs, expv); end
    endtask

    task automatic test_shift_logic;
        run_op(OP_ROR, 8'h01, 8'h00, 1'b1, 1'b0);
        expv = {1'b1, 4'd2, 8'h80, 4'b1001, 4'b1011, 1'b1}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL ror: got %h, expected %h", obs, expv); end
        run_op(OP_LSR, 8'h01, 8'h00, 1'b1, 1'b0);
        expv = {1'b1, 4'd2, 8'h00, 4'b0011, 4'b1011, 1'b1}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL lsr: got %h, expected %h", obs, expv); end
        run_op(OP_ASL, 8'h81, 8'h00, 1'b1, 1'b0);
        expv = {1'b1, 4'd2, 8'h02, 4'b0101, 4'b1011, 1'b1}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL asl: got %h, expected %h", obs, expv); end
        run_op(OP_ROL, 8'h80, 8'h00, 1'b1, 1'b0);
        expv = {1'b1, 4'd2, 8'h01, 4'b0101, 4'b1011, 1'b1}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL rol: got %h, expected %h", obs, expv); end
        run_op(OP_DEC, 8'h00, 8'h00, 1'b0, 1'b0);
        expv = {1'b1, 4'd2, 8'hFF, 4'b1000, 4'b1010, 1'b1}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL dec: got %h, expected %h", obs, expv); end
        run_op(OP_INC, 8'hFF, 8'h00, 1'b0, 1'b0);
        expv = {1'b1, 4'd2, 8'h00, 4'b0011, 4'b1010, 1'b1}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL inc: got %h, expected %h", obs, expv); end
        run_op(OP_AND, 8'hF0, 8'h3C, 1'b1, 1'b0);
        expv = {1'b1, 4'd2, 8'h30, 4'b0000, 4'b1010, 1'b1}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL and: got %h, expected %h", obs, expv); end
        run_op(OP_EOR, 8'hFF, 8'h0F, 1'b0, 1'b0);
        expv = {1'b1, 4'd2, 8'hF0, 4'b1000, 4'b1010, 1'b1}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL eor: got %h, expected %h", obs, expv); end
        run_op(OP_ORA, 8'h00, 8'h00, 1'b0, 1'b0);
        expv = {1'b1, 4'd2, 8'h00, 4'b0010, 4'b1010, 1'b1}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL ora: got %h, expected %h", obs, expv); end
    endtask

    task automatic test_unknown_op;
        run_op(4'hF, 8'h55, 8'hAA, 1'b1, 1'b1);
        expv = {1'b1, 4'd2, 8'h00, 4'b0000, 4'b0000, 1'b0}; checks++;
        if (obs !== expv) begin errors++; $display("FAIL unknown_op: got %h, expected %h", obs, expv); end
    endtask

    task automatic test_alu_drive;
        @(negedge clk);
        req_op = OP_SBC; req_a = 8'h46; req_b = 8'h12; req_carry = 1'b1; req_decimal = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({alu_control, alu_AI, alu_BI, alu_carry_in} !== {ALU_ADD, 8'h46, 8'hED, 1'b1}) begin
            errors++;
            $display("FAIL sbc_exec_drive: got ctl=%h ai=%h bi=%h cin=%b, expected 0 46 ed 1",
                     alu_control, alu_AI, alu_BI, alu_carry_in);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [5:0] rdy_pat;
        int acc, rv;
        logic data_ok;
        rdy_pat = 6'b0; acc = 0; rv = 0; data_ok = 1'b1;
        @(negedge clk);
        req_op = OP_ADC; req_a = 8'h01; req_b = 8'h01; req_carry = 1'b0; req_decimal = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            rdy_pat[5-i] = req_ready;
            if (req_valid && req_ready) acc++;
            if (res_valid) begin
                rv++;
                if (res_data !== 8'h02) data_ok = 1'b0;
            end
        end
        req_valid = 1'b0;
        checks++;
        if (rdy_pat !== 6'b100100) begin errors++; $display("FAIL b2b_ready: got %b, expected 100100", rdy_pat); end
        checks++;
        if (acc !== 2) begin errors++; $display("FAIL b2b_accepts: got %0d, expected 2", acc); end
        checks++;
        if (rv !== 2 || !data_ok) begin errors++; $display("FAIL b2b_results: got %0d ok=%b, expected 2 ok=1", rv, data_ok); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_in_adjust;
        int rv;
        rv = 0;
        @(negedge clk);
        req_op = OP_ADC; req_a = 8'h19; req_b = 8'h28; req_carry = 1'b0; req_decimal = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        // now in ADJUST: binary 0x41 gets +0x06
        checks++;
        if ({alu_control, alu_AI, alu_BI, alu_carry_in} !== {ALU_ADD, 8'h41, 8'h06, 1'b0}) begin
            errors++;
            $display("FAIL adjust_drive: got ctl=%h ai=%h bi=%h cin=%b, expected 0 41 06 0",
                     alu_control, alu_AI, alu_BI, alu_carry_in);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({req_ready, res_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_adjust_state: got rdy=%b v=%b, expected rdy=1 v=0", req_ready, res_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (res_valid) rv++;
        end
        checks++;
        if (rv !== 0) begin errors++; $display("FAIL reset_adjust_drop: got %0d pulses, expected 0", rv); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_compare();
        test_shift_logic();
        test_unknown_op();
        test_alu_drive();
        test_back_to_back();
        test_reset_in_adjust();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
